// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard controller: bypass selects and
// Tuse/Tnew constants (sized for the default 2-bit Tnew/Tuse fields).
package hazard_defs;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] TUSE_NONE = 2'b11;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

endpackage

// File: rtl/fwd_hazard_unit_stage_rec.sv
// One shadow pipeline record {v, we, wa, tnew}; optionally decrements the
// incoming tnew (saturating at 0) as the writer advances a stage.
module hazard_stage_rec
  import hazard_defs::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned TNEW_W = 2,
  parameter bit          DEC    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_v,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [TNEW_W-1:0] i_tnew,
  output logic              o_v,
  output logic              o_we,
  output logic [REG_AW-1:0] o_wa,
  output logic [TNEW_W-1:0] o_tnew
);

  logic              r_v;
  logic              r_we;
  logic [REG_AW-1:0] r_wa;
  logic [TNEW_W-1:0] r_tnew;
  logic [TNEW_W-1:0] w_tnew_nxt;

  always_comb begin
    w_tnew_nxt = i_tnew;
    if (DEC && (i_tnew != '0)) w_tnew_nxt = i_tnew - TNEW_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= 1'b0;
      r_we   <= 1'b0;
      r_wa   <= '0;
      r_tnew <= '0;
    end else begin
      r_v    <= i_v;
      r_we   <= i_we;
      r_wa   <= i_wa;
      r_tnew <= w_tnew_nxt;
    end
  end

  assign o_v    = r_v;
  assign o_we   = r_we;
  assign o_wa   = r_wa;
  assign o_tnew = r_tnew;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding / stall controller for the 5-stage MIPS pipeline, driven from
// shadow E/M/W writer records plus a multiply/divide busy counter.
module fwd_hazard_unit
  import hazard_defs::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned TNEW_W   = 2,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TNEW_W-1:0] d_rs_tuse,
  input  logic [TNEW_W-1:0] d_rt_tuse,
  input  logic              d_we,
  input  logic [REG_AW-1:0] d_wa,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  input  logic [REG_AW-1:0] e_rs,
  input  logic [REG_AW-1:0] e_rt,
  input  logic [REG_AW-1:0] m_rt,
  input  logic              flush_e,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic              md_busy
);

  logic              w_e_v, w_e_we, w_m_v, w_m_we, w_w_v, w_w_we;
  logic [REG_AW-1:0] w_e_wa, w_m_wa, w_w_wa;
  logic [TNEW_W-1:0] w_e_tnew, w_m_tnew, w_w_tnew;
  logic              w_e_load, w_m_rdy, w_w_rdy;
  logic              w_tnew_stall, w_md_stall, w_stall, w_md_busy;
  logic              r_e_md_start, r_e_md_div;
  logic [CNT_W-1:0]  r_md_cnt;

  function automatic logic f_match(input logic v, input logic we,
                                   input logic [REG_AW-1:0] wa,
                                   input logic [REG_AW-1:0] r);
    return v & we & (wa == r) & (r != '0);
  endfunction

  // A matching M writer that is not ready shadows any older W value.
  function automatic fwd_sel_e f_fwd(input logic m_hit, input logic m_rdy,
                                     input logic w_hit, input logic w_rdy);
    if (m_hit)              return m_rdy ? FWD_M : FWD_RF;
    else if (w_hit && w_rdy) return FWD_W;
    else                     return FWD_RF;
  endfunction

  hazard_stage_rec #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .DEC(1'b0)) u_rec_e (
    .clk(clk), .rst_n(reset),
    .i_v(w_e_load), .i_we(d_we), .i_wa(d_wa), .i_tnew(d_tnew),
    .o_v(w_e_v), .o_we(w_e_we), .o_wa(w_e_wa), .o_tnew(w_e_tnew)
  );

  hazard_stage_rec #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .DEC(1'b1)) u_rec_m (
    .clk(clk), .rst_n(reset),
    .i_v(w_e_v), .i_we(w_e_we), .i_wa(w_e_wa), .i_tnew(w_e_tnew),
    .o_v(w_m_v), .o_we(w_m_we), .o_wa(w_m_wa), .o_tnew(w_m_tnew)
  );

  hazard_stage_rec #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .DEC(1'b1)) u_rec_w (
    .clk(clk), .rst_n(reset),
    .i_v(w_m_v), .i_we(w_m_we), .i_wa(w_m_wa), .i_tnew(w_m_tnew),
    .o_v(w_w_v), .o_we(w_w_we), .o_wa(w_w_wa), .o_tnew(w_w_tnew)
  );

  assign w_tnew_stall =
      (f_match(w_e_v, w_e_we, w_e_wa, d_rs) && (w_e_tnew > d_rs_tuse)) ||
      (f_match(w_m_v, w_m_we, w_m_wa, d_rs) && (w_m_tnew > d_rs_tuse)) ||
      (f_match(w_e_v, w_e_we, w_e_wa, d_rt) && (w_e_tnew > d_rt_tuse)) ||
      (f_match(w_m_v, w_m_we, w_m_wa, d_rt) && (w_m_tnew > d_rt_tuse));

  assign w_md_busy  = (r_md_cnt != '0);
  assign w_md_stall = d_md_use & (w_md_busy | r_e_md_start);
  assign w_stall    = d_valid & (w_tnew_stall | w_md_stall);
  assign w_e_load   = d_valid & ~w_stall & ~flush_e;

  // md_start is captured already qualified by the E load, so it implies E.v.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_md_start <= 1'b0;
      r_e_md_div   <= 1'b0;
      r_md_cnt     <= '0;
    end else begin
      r_e_md_start <= w_e_load & d_md_start;
      r_e_md_div   <= d_md_div;
      if (r_e_md_start)
        r_md_cnt <= r_e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (r_md_cnt != '0)
        r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  assign w_m_rdy = (w_m_tnew == '0);
  assign w_w_rdy = (w_w_tnew == '0);

  assign stall    = w_stall;
  assign md_busy  = w_md_busy;
  assign fwd_rs_d = w_stall ? FWD_RF :
                    f_fwd(f_match(w_m_v, w_m_we, w_m_wa, d_rs), w_m_rdy,
                          f_match(w_w_v, w_w_we, w_w_wa, d_rs), w_w_rdy);
  assign fwd_rt_d = w_stall ? FWD_RF :
                    f_fwd(f_match(w_m_v, w_m_we, w_m_wa, d_rt), w_m_rdy,
                          f_match(w_w_v, w_w_we, w_w_wa, d_rt), w_w_rdy);
  assign fwd_rs_e = f_fwd(f_match(w_m_v, w_m_we, w_m_wa, e_rs), w_m_rdy,
                          f_match(w_w_v, w_w_we, w_w_wa, e_rs), w_w_rdy);
  assign fwd_rt_e = f_fwd(f_match(w_m_v, w_m_we, w_m_wa, e_rt), w_m_rdy,
                          f_match(w_w_v, w_w_we, w_w_wa, e_rt), w_w_rdy);
  assign fwd_rt_m = f_match(w_w_v, w_w_we, w_w_wa, m_rt);

endmodule
